// File: rtl/fp16_pkg.sv
// Shared constants for the FP16 add/sub arbiter slice.
//   FP16_W   : width of an IEEE-754 half-precision word
//   OP_ADD/OP_SUB : encodings carried on req_op / dp_op
//   OVF_W    : width of the saturating overflow counter
package fp16_pkg;
    localparam int   FP16_W = 16;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int   OVF_W  = 8;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among NREQ requesters.
//   req_i : eligible requesters (already masked by busy/reset)
//   ptr_i : index of the last granted requester; search starts at ptr_i+1
//   gnt_o : one-hot grant, zero when nothing is eligible
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);
    always_comb begin
        int  idx;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        // Offsets 1..NREQ so the last winner is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp16_addsub_arbiter.sv
// Shares one external FP16 add/sub datapath among NREQ requesters.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/ready     : per-requester handshake (ready is the one-hot grant)
//   req_a/req_b/req_op  : packed per-requester operands and operation
//   dp_valid/a/b/op     : zero-latency issue to the datapath
//   dp_res/dp_ovf       : datapath result, LAT cycles after issue
//   rsp_valid/data/ovf  : registered one-hot result pulse to the owner
//   ovf_count           : saturating count of overflowed results
module fp16_addsub_arbiter
    import fp16_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [FP16_W*NREQ-1:0] req_a,
    input  logic [FP16_W*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]        req_op,
    output logic                   dp_valid,
    output logic [FP16_W-1:0]      dp_a,
    output logic [FP16_W-1:0]      dp_b,
    output logic                   dp_op,
    input  logic [FP16_W-1:0]      dp_res,
    input  logic                   dp_ovf,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [FP16_W-1:0]      rsp_data,
    output logic                   rsp_ovf,
    output logic [OVF_W-1:0]       ovf_count
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]         busy_q, busy_d;
    logic [NREQ-1:0]         elig, gnt;
    logic [IW-1:0]           ptr_q, ptr_d, gidx;
    logic [LAT:1]            vld_pipe_q;
    logic [LAT:1][IW-1:0]    idx_pipe_q;
    logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [FP16_W-1:0]       rsp_data_q, rsp_data_d;
    logic                    rsp_ovf_q, rsp_ovf_d;
    logic [OVF_W-1:0]        ovf_cnt_q, ovf_cnt_d;

    // Reset masks eligibility so no grant or issue appears while rst=1.
    assign elig = rst ? '0 : (req_valid & ~busy_q);

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign req_ready = gnt;
    assign dp_valid  = |gnt;

    // One-hot mux: with no grant every term is masked, so idle outputs are 0.
    always_comb begin
        gidx = '0;
        dp_a = '0;
        dp_b = '0;
        dp_op = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gidx = IW'(i);
            dp_a  = dp_a  | ({FP16_W{gnt[i]}} & req_a[FP16_W*i +: FP16_W]);
            dp_b  = dp_b  | ({FP16_W{gnt[i]}} & req_b[FP16_W*i +: FP16_W]);
            dp_op = dp_op | (gnt[i] & req_op[i]);
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_ovf_d   = 1'b0;
        if (vld_pipe_q[LAT]) begin
            rsp_valid_d[idx_pipe_q[LAT]] = 1'b1;
            rsp_data_d = dp_res;
            rsp_ovf_d  = dp_ovf;
        end
        // Busy stays set through the pulse cycle, so a re-grant lands one
        // cycle after rsp_valid. Set and clear never hit the same bit.
        busy_d    = (busy_q & ~rsp_valid_q) | gnt;
        ptr_d     = dp_valid ? gidx : ptr_q;
        ovf_cnt_d = (rsp_ovf_q && (ovf_cnt_q != '1)) ? ovf_cnt_q + 1'b1 : ovf_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            ptr_q       <= IW'(NREQ-1);
            vld_pipe_q  <= '0;
            idx_pipe_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            busy_q        <= busy_d;
            ptr_q         <= ptr_d;
            vld_pipe_q[1] <= dp_valid;
            idx_pipe_q[1] <= gidx;
            for (int k = 2; k <= LAT; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                idx_pipe_q[k] <= idx_pipe_q[k-1];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign ovf_count = ovf_cnt_q;
endmodule

// File: tb/tb_fp16_addsub_arbiter.sv
module tb_fp16_addsub_arbiter;
    import fp16_pkg::*;
    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready, req_op, rsp_valid;
    logic [63:0] req_a, req_b;
    logic        dp_valid, dp_op, dp_ovf, rsp_ovf;
    logic [15:0] dp_a, dp_b, dp_res, rsp_data;
    logic [7:0]  ovf_count;

    int compared   = 0;
    int mismatched = 0;
    logic ovf_mode = 1'b0;

    always #5 clk = ~clk;

    fp16_addsub_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
        .dp_res(dp_res), .dp_ovf(dp_ovf),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
        .ovf_count(ovf_count)
    );

    // Stand-in datapath: fixed LAT-cycle pipeline. 0x3C00+0x3C00 returns the
    // true half result 0x4000; anything else returns integer a+b / a-b.
    logic [LAT:1] mv = '0;
    logic [15:0]  mr [1:LAT];
    logic         mo [1:LAT];

    function automatic logic [15:0] f(input logic [15:0] a, input logic [15:0] b, input logic op);
        if (a == 16'h3C00 && b == 16'h3C00 && op == OP_ADD) return 16'h4000;
        return (op == OP_SUB) ? a - b : a + b;
    endfunction

    always @(posedge clk) begin
        mv[1] <= dp_valid;
        mr[1] <= f(dp_a, dp_b, dp_op);
        mo[1] <= ovf_mode;
        for (int k = 2; k <= LAT; k++) begin
            mv[k] <= mv[k-1];
            mr[k] <= mr[k-1];
            mo[k] <= mo[k-1];
        end
    end
    assign dp_res = mv[LAT] ? mr[LAT] : 16'h0;
    assign dp_ovf = mv[LAT] ? mo[LAT] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic op);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_op[i]         = op;
    endtask

    // Hold mask asserted until target transfers have been seen (bounded).
    task automatic issue_n(input logic [3:0] mask, input int target, input int budget, input string tag);
        int n = 0;
        int cyc = 0;
        while (n < target && cyc < budget) begin
            req_valid = mask;
            #1;
            if (dp_valid) n++;
            tick();
            cyc++;
        end
        req_valid = 4'h0;
        chk(tag, n, target);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'hF;
        req_a = '0; req_b = '0; req_op = '0;
        tick(); tick(); tick();
        #1;
        chk("rst_ready", req_ready, 4'h0);
        chk("rst_dpv", dp_valid, 1'b0);
        chk("rst_dpa", dp_a, 16'h0);
        chk("rst_rspv", rsp_valid, 4'h0);
        chk("rst_rspd", rsp_data, 16'h0);
        chk("rst_ovfc", ovf_count, 8'h0);

        // Four requesters raised together: grants 0,1,2,3 then stall.
        set_req(0, 16'h1000, 16'h0001, OP_ADD);
        set_req(1, 16'h2000, 16'h0002, OP_SUB);
        set_req(2, 16'h3000, 16'h0003, OP_ADD);
        set_req(3, 16'h4000, 16'h0004, OP_SUB);
        rst = 1'b0;
        #1;
        chk("g0_ready", req_ready, 4'b0001);
        chk("g0_dpv", dp_valid, 1'b1);
        chk("g0_dpa", dp_a, 16'h1000);
        chk("g0_dpb", dp_b, 16'h0001);
        chk("g0_dpop", dp_op, 1'b0);
        tick(); #1;
        chk("g1_ready", req_ready, 4'b0010);
        chk("g1_dpop", dp_op, 1'b1);
        chk("g1_dpa", dp_a, 16'h2000);
        tick(); #1;
        chk("g2_ready", req_ready, 4'b0100);
        chk("g2_dpa", dp_a, 16'h3000);
        tick(); #1;
        chk("g3_ready", req_ready, 4'b1000);
        chk("g3_dpb", dp_b, 16'h0004);
        tick(); #1;
        chk("c4_ready", req_ready, 4'b0000);
        chk("c4_idle_dpa", dp_a, 16'h0);
        chk("c4_idle_dpop", dp_op, 1'b0);
        chk("r0_valid", rsp_valid, 4'b0001);
        chk("r0_data", rsp_data, 16'h1001);
        chk("r0_ovf", rsp_ovf, 1'b0);
        req_valid = 4'h0;
        tick(); #1;
        chk("r1_valid", rsp_valid, 4'b0010);
        chk("r1_data", rsp_data, 16'h1FFE);
        tick(); #1;
        chk("r2_valid", rsp_valid, 4'b0100);
        chk("r2_data", rsp_data, 16'h3003);
        tick(); #1;
        chk("r3_valid", rsp_valid, 4'b1000);
        chk("r3_data", rsp_data, 16'h3FFC);
        tick(); #1;
        chk("idle_rspv", rsp_valid, 4'h0);
        chk("idle_rspd", rsp_data, 16'h0);

        // Requester 2: 1.0 + 1.0 -> 2.0 at t+4.
        set_req(2, 16'h3C00, 16'h3C00, OP_ADD);
        req_valid = 4'b0100;
        #1;
        chk("t_ready", req_ready, 4'b0100);
        chk("t_dpa", dp_a, 16'h3C00);
        tick(); req_valid = 4'h0;
        tick(); tick(); #1;
        chk("t3_rspv", rsp_valid, 4'h0);
        tick(); #1;
        chk("t4_rspv", rsp_valid, 4'b0100);
        chk("t4_rspd", rsp_data, 16'h4000);
        chk("t4_ovf", rsp_ovf, 1'b0);
        tick();

        // Requester 1 holds valid: no re-grant until after its pulse.
        set_req(1, 16'h5000, 16'h0100, OP_SUB);
        req_valid = 4'b0010;
        #1;
        chk("h_g0", req_ready, 4'b0010);
        for (int k = 1; k <= 4; k++) begin
            tick(); #1;
            chk("h_wait_ready", req_ready, 4'b0000);
            if (k == 4) begin
                chk("h_pulse", rsp_valid, 4'b0010);
                chk("h_data", rsp_data, 16'h4F00);
            end
        end
        tick(); #1;
        chk("h_regrant", req_ready, 4'b0010);
        req_valid = 4'h0;
        tick();

        // Issue to 3 in the same cycle as a response to 0.
        set_req(0, 16'h0100, 16'h0100, OP_ADD);
        req_valid = 4'b0001;
        #1;
        chk("u_g0", req_ready, 4'b0001);
        tick(); req_valid = 4'h0;
        tick(); tick(); tick();
        set_req(3, 16'h0200, 16'h0080, OP_SUB);
        req_valid = 4'b1000;
        #1;
        chk("u4_rspv", rsp_valid, 4'b0001);
        chk("u4_rspd", rsp_data, 16'h0200);
        chk("u4_ready", req_ready, 4'b1000);
        tick();
        req_valid = 4'b1001;
        #1;
        chk("u5_ready", req_ready, 4'b0001);
        tick(); req_valid = 4'h0;
        tick(); tick(); #1;
        chk("u8_rspv", rsp_valid, 4'b1000);
        chk("u8_rspd", rsp_data, 16'h0180);
        tick(); #1;
        chk("u9_rspv", rsp_valid, 4'b0001);
        chk("u9_rspd", rsp_data, 16'h0200);
        tick();

        // Overflow counting and saturation.
        ovf_mode = 1'b1;
        issue_n(4'hF, 4, 100, "ovf_issue4");
        repeat (6) tick();
        chk("ovf_cnt4", ovf_count, 8'd4);
        issue_n(4'hF, 296, 3000, "ovf_issue296");
        repeat (6) tick();
        chk("ovf_sat", ovf_count, 8'd255);
        issue_n(4'hF, 4, 100, "ovf_issue_more");
        repeat (6) tick();
        chk("ovf_stay", ovf_count, 8'd255);
        ovf_mode = 1'b0;

        // Reset with three operations in flight.
        issue_n(4'b0111, 3, 100, "rst_issue3");
        rst = 1'b1;
        tick();
        #1;
        chk("mid_rst_ready", req_ready, 4'h0);
        chk("mid_rst_ovfc", ovf_count, 8'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(); #1;
            chk("post_rst_rspv", rsp_valid, 4'h0);
        end
        req_valid = 4'hF;
        #1;
        chk("post_rst_g0", req_ready, 4'b0001);
        req_valid = 4'h0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fp16_addsub_arbiter.md
FP16_ADDSUB_ARBITER -- requirements
Module: fp16_addsub_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter LAT, default 3, meaning the fixed issue-to-result latency of the shared FP16 add/sub datapath in cycles (1..8).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning a synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NREQ  meaning per-requester operation valid.
REQ-006 SHALL have port req_ready  output  NREQ  meaning per-requester grant (accept this cycle).
REQ-007 SHALL have port req_a  input  16*NREQ  meaning IEEE-754 half operand A; requester i occupies bits [16i+15:16i].
REQ-008 SHALL have port req_b  input  16*NREQ  meaning half operand B, packed as req_a.
REQ-009 SHALL have port req_op  input  NREQ  meaning per-requester operation, 0=add, 1=sub.
REQ-010 SHALL have port dp_valid  output  1  meaning issue strobe to the shared datapath.
REQ-011 SHALL have port dp_a / dp_b  output  16 each  meaning the issued operands.
REQ-012 SHALL have port dp_op  output  1  meaning the issued operation.
REQ-013 SHALL have port dp_res  input  16  meaning the datapath result, valid exactly LAT cycles after the dp_valid cycle.
REQ-014 SHALL have port dp_ovf  input  1  meaning the datapath overflow flag, aligned with dp_res.
REQ-015 SHALL have port rsp_valid  output  NREQ  meaning one-hot, one-cycle result pulse to the owning requester.
REQ-016 SHALL have port rsp_data  output  16  meaning the result, shared by all requesters and qualified by rsp_valid.
REQ-017 SHALL have port rsp_ovf  output  1  meaning the overflow flag for rsp_data.
REQ-018 SHALL have port ovf_count  output  8  meaning the saturating count of overflowed results since reset.

Function
REQ-019 SHALL grant at most one requester per cycle; req_ready SHALL be one-hot or zero.
REQ-020 SHALL grant requester i only if req_valid[i]=1 and i has no operation in flight; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-021 SHALL arbitrate round-robin: the search starts at (last granted index + 1) mod NREQ; after reset the pointer SHALL be NREQ-1, so requester 0 has first priority.
REQ-022 SHALL make req_ready combinational from req_valid, the busy bits and the pointer, and SHALL NOT wait for req_ready before requests are raised.
REQ-023 SHALL, on a transfer, drive dp_valid=1 with dp_a/dp_b/dp_op equal to the granted requester's inputs in the same cycle (zero issue latency).
REQ-024 SHALL drive dp_a, dp_b and dp_op to 0 when dp_valid=0.
REQ-025 SHALL carry a valid bit plus a requester index through a LAT-deep shift pipeline, so the owner of each result is known LAT cycles after issue.
REQ-026 SHALL register the response: rsp_valid[i], rsp_data and rsp_ovf SHALL assert LAT+1 cycles after the issue cycle, capturing the dp_res and dp_ovf present at cycle LAT.
REQ-027 SHALL drive rsp_data=0 and rsp_ovf=0 whenever no rsp_valid bit is set.
REQ-028 SHALL set busy[i] on issue and clear it in the cycle rsp_valid[i] pulses.
REQ-029 SHALL allow requester i to be re-granted in the cycle after its rsp_valid pulse, and not earlier.
REQ-030 SHALL allow back-to-back issue from different requesters, up to NREQ in flight at once.
REQ-031 SHALL increment ovf_count on each response with rsp_ovf=1 and saturate it at 255.
REQ-032 SHALL handle an issue and a response for different requesters in the same cycle independently.
REQ-033 SHALL NOT check operand values; NaN, Inf and denormals pass through to the datapath unchanged.

Reset
REQ-034 SHALL, while rst=1, clear req_ready, dp_valid, dp_a, dp_b, dp_op, rsp_valid, rsp_data, rsp_ovf, ovf_count, all busy bits and every pipeline valid bit, and set the pointer to NREQ-1.
REQ-035 SHALL discard in-flight operations on a reset asserted mid-operation; no rsp_valid SHALL pulse for them after reset deasserts.

Structure
REQ-036 SHALL place FP16_W=16, the OP_ADD/OP_SUB encodings and the ovf_count width in a shared package, fp16_pkg.
REQ-037 SHALL implement the round-robin pick as one sub-module, rr_arbiter (inputs: request and pointer; output: one-hot grant).
REQ-038 SHALL keep the datapath external to this block.

Verification
REQ-039 SHALL cover: after reset, req_valid=4'b1111 held -> grants in order 0,1,2,3, one per cycle; then no grants until the responses return.
REQ-040 SHALL cover: LAT=3, requester 2 issues 0x3C00+0x3C00 at cycle t, model returns 0x4000 -> rsp_valid=4'b0100 and rsp_data=0x4000 at t+4.
REQ-041 SHALL cover: requester 1 holds req_valid -> it is re-granted no earlier than the cycle after its rsp_valid pulse.
REQ-042 SHALL cover: 300 issues with dp_ovf=1 -> ovf_count=255 and stays at 255.
REQ-043 SHALL cover: rst pulsed while 3 operations are in flight -> no rsp_valid afterwards, pointer restored, requester 0 granted first.
REQ-044 SHALL cover: an issue to requester 3 in the same cycle as a response to requester 0 -> both occur and busy bits stay consistent.
